mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single synchronous memory port (mem_cs_en_ctl / mem_wen_ctl / mem_addr_ctl / mem_wdata_ctl / mem_rdata_top) between the fetch requester and the data requester (load/store).
- Grants at most one access per cycle, routes the one-cycle-late read data back to its owner, and produces stall requests for the pipeline controller.
- Honours ext_hold_top.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive denied fetch cycles after which fetch wins one grant (only with the optional feature)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_b  in  1  synchronous reset, active-high (asserted = 1, despite the suffix)
- ext_hold_top  in  1  external hold; no new grants while 1
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch granted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetch read data
- d_req  in  1  data access request
- d_wen  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data granted this cycle
- d_rvalid  out  1  load data valid (never for stores)
- d_rdata  out  DATA_W  load data
- hold_if_req  out  1  if_req & ~if_gnt
- hold_d_req  out  1  d_req & ~d_gnt
- mem_cs_en_ctl  out  1  memory chip select
- mem_wen_ctl  out  1  memory write enable
- mem_addr_ctl  out  ADDR_W  memory address
- mem_wdata_ctl  out  DATA_W  memory write data
- mem_rdata_top  in  DATA_W  memory read data, valid the cycle after a read grant

Behaviour:
- Reset: all outputs 0; state ARB_IDLE; owner OWN_NONE; starvation counter 0; response buffer 0. A response outstanding at reset is dropped.
- Grant is combinational in the request cycle.
  - When ext_hold_top = 0 and state != ARB_HOLD: d_req wins over if_req; fetch is granted only when d_req = 0, or the starvation override applies.
  - The mem_* outputs mirror the granted requester in the same cycle. When nothing is granted, mem_cs_en_ctl = 0, mem_wen_ctl = 0, and address and data are 0.
- Read latency is 1: a read granted in cycle N asserts the owner's rvalid in N+1, with rdata = mem_rdata_top.
  - A store grant produces no rvalid.
  - Back-to-back grants are allowed: a new grant in N+1 is legal while response N is being delivered.
- FSM (response path):
  - ARB_IDLE: no response due. A read grant goes to ARB_RESP and the owner is recorded.
  - ARB_RESP: deliver the response.
    - If ext_hold_top = 1, latch mem_rdata_top into the response buffer and go to ARB_HOLD.
    - Otherwise go to ARB_RESP if this cycle issues another read grant, else ARB_IDLE.
  - ARB_HOLD: rvalid/rdata are driven from the buffer, stable, and no grants are issued. On the first cycle with ext_hold_top = 0, rvalid stays 1 for that cycle, then go to ARB_IDLE.
- Simultaneous if_req and d_req under hold: neither is granted, and both hold_* are 1.
- A fetch and a store to the same address in the same cycle: the store wins, and the fetch sees the new data on its later grant.
- Address alignment is not checked here; the execute stage owns misalignment exceptions.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - The counter increments on cycles with if_req & ~if_gnt & ~ext_hold_top and saturates at STARVE_MAX.
  - It clears on if_gnt, or on if_req = 0.
  - When it equals STARVE_MAX and the arbiter may grant, fetch is granted over d_req and the counter clears.
- Undefined: strict data priority; no counter logic is synthesised.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (ARB_IDLE, ARB_RESP, ARB_HOLD);
  - the owner encoding (OWN_NONE, OWN_IF, OWN_D);
  - the STARVE_W width function.
- One sub-module, mem_arb_resp_buf: the owner register plus the hold latch, producing the rvalid/rdata pairs.

Test Plan:
- Fetch only: if_req = 1, if_addr = 0x100 for 3 cycles; memory returns 0xA0, 0xA1, 0xA2 -> if_gnt = 1 each cycle, and if_rvalid = 1 in cycles 2-4 with those data in order.
- Contention: if_req = d_req = 1, d_wen = 0, d_addr = 0x200 -> d_gnt = 1, if_gnt = 0, hold_if_req = 1, mem_addr_ctl = 0x200; d_rvalid next cycle, if_rvalid = 0.
- Store: d_req = 1, d_wen = 1, d_addr = 0x40, d_wdata = 0xDEADBEEF -> mem_wen_ctl = 1, mem_wdata_ctl = 0xDEADBEEF, and no d_rvalid the next cycle.
- Hold mid-response: read granted in cycle N, ext_hold_top = 1 in N+1..N+3 with mem_rdata_top = 0x1234 in N+1 and garbage afterwards -> if_rvalid = 1 with if_rdata = 0x1234 through N+4, and no grants in N+1..N+3.
- Starvation guard on, STARVE_MAX = 4: d_req and if_req held high -> d_gnt for 4 cycles, if_gnt in cycle 5, then d_gnt resumes. With the guard off -> if_gnt never asserts.
- Synchronous reset asserted during ARB_HOLD -> next cycle all outputs 0 and state ARB_IDLE; the buffered response is never delivered.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: response FSM states, response owner
// encoding and the starvation counter width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RESP = 2'd1,
    ARB_HOLD = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // Bits needed to count 0..max_count inclusive.
  function automatic int starve_w(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/mem_arb_resp_buf.sv
// Response routing for the memory port arbiter: remembers who owns the read in
// flight and keeps the read data stable while the pipeline is held.
module mem_arb_resp_buf
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  arb_state_e        state,
  input  arb_state_e        state_next,
  input  owner_e            grant_owner,
  input  logic              latch_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata
);

  owner_e            owner_q;
  logic [DATA_W-1:0] buf_q;
  logic [DATA_W-1:0] resp_data;
  logic              resp_active;

  always_ff @(posedge clk) begin
    if (rst_b) begin
      owner_q <= OWN_NONE;
      buf_q   <= '0;
    end else begin
      if (latch_en)
        buf_q <= mem_rdata;
      if (grant_owner != OWN_NONE)
        owner_q <= grant_owner;
      else if (state_next == ARB_IDLE)
        owner_q <= OWN_NONE;
    end
  end

  // Fresh data comes straight from memory; once held, the buffer takes over.
  always_comb begin
    resp_active = (state != ARB_IDLE);
    resp_data   = (state == ARB_HOLD) ? buf_q : mem_rdata;
    if_rvalid   = resp_active && (owner_q == OWN_IF);
    d_rvalid    = resp_active && (owner_q == OWN_D);
    if_rdata    = if_rvalid ? resp_data : '0;
    d_rdata     = d_rvalid ? resp_data : '0;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single synchronous memory port between fetch and data accesses.
// Define MEM_ARB_STARVE_GUARD_EN to let a starved fetch win one grant.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              ext_hold_top,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              hold_if_req,
  output logic              hold_d_req,
  output logic              mem_cs_en_ctl,
  output logic              mem_wen_ctl,
  output logic [ADDR_W-1:0] mem_addr_ctl,
  output logic [DATA_W-1:0] mem_wdata_ctl,
  input  logic [DATA_W-1:0] mem_rdata_top,
  output logic [1:0]        dbg_state
);

  // Handshake: a request is a level held by the requester; the cycle in which
  // its gnt is 1 is the cycle the access is issued. Read data returns exactly
  // one cycle later with rvalid, or stays valid longer while ext_hold_top holds.

  arb_state_e state_q, state_next;
  owner_e     grant_owner;
  logic       may_grant;
  logic       starve_win;
  logic       latch_en;

  assign may_grant = ~ext_hold_top & (state_q != ARB_HOLD);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SW = starve_w(STARVE_MAX);
  logic [SW-1:0] starve_cnt;

  assign starve_win = (starve_cnt == SW'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (rst_b)
      starve_cnt <= '0;
    else if (if_gnt || !if_req)
      starve_cnt <= '0;
    else if (!ext_hold_top && !starve_win)
      starve_cnt <= starve_cnt + SW'(1);
  end
`else
  // Strict data priority; only a negative threshold could ever be true here.
  assign starve_win = (STARVE_MAX < 0);
`endif

  always_comb begin
    if_gnt        = may_grant & if_req & (~d_req | starve_win);
    d_gnt         = may_grant & d_req & ~if_gnt;
    hold_if_req   = if_req & ~if_gnt;
    hold_d_req    = d_req & ~d_gnt;
    mem_cs_en_ctl = if_gnt | d_gnt;
    mem_wen_ctl   = d_gnt & d_wen;
    mem_addr_ctl  = '0;
    mem_wdata_ctl = '0;
    grant_owner   = OWN_NONE;
    if (d_gnt) begin
      mem_addr_ctl  = d_addr;
      mem_wdata_ctl = d_wdata;
      if (!d_wen)
        grant_owner = OWN_D;
    end else if (if_gnt) begin
      mem_addr_ctl = if_addr;
      grant_owner  = OWN_IF;
    end
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      ARB_IDLE: state_next = (grant_owner != OWN_NONE) ? ARB_RESP : ARB_IDLE;
      ARB_RESP: begin
        if (ext_hold_top)
          state_next = ARB_HOLD;
        else
          state_next = (grant_owner != OWN_NONE) ? ARB_RESP : ARB_IDLE;
      end
      ARB_HOLD: state_next = ext_hold_top ? ARB_HOLD : ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b)
      state_q <= ARB_IDLE;
    else
      state_q <= state_next;
  end

  assign latch_en  = (state_q == ARB_RESP) & ext_hold_top;
  assign dbg_state = state_q;

  mem_arb_resp_buf #(.DATA_W(DATA_W)) u_resp_buf (
    .clk        (clk),
    .rst_b      (rst_b),
    .state      (state_q),
    .state_next (state_next),
    .grant_owner(grant_owner),
    .latch_en   (latch_en),
    .mem_rdata  (mem_rdata_top),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata)
  );

endmodule
